// File: rtl/skeleton_keypoint_extractor_pkg.sv
// Shared types and helpers for the skeleton keypoint extractor.
// Coordinates inside a point_t are sized for the largest supported frame.
// Instances with smaller frames zero-extend their coordinates into these fields.
package skel_pkg;

    localparam int MAX_HORIZONTAL_COUNT = 320;
    localparam int MAX_VERTICAL_COUNT   = 180;
    localparam int POINT_X_WIDTH        = $clog2(MAX_HORIZONTAL_COUNT);
    localparam int POINT_Y_WIDTH        = $clog2(MAX_VERTICAL_COUNT);

    typedef enum logic {
        ENDPOINT = 1'b0,
        JUNCTION = 1'b1
    } point_type_e;

    typedef struct packed {
        logic [POINT_X_WIDTH-1:0] point_x;
        logic [POINT_Y_WIDTH-1:0] point_y;
        point_type_e              point_kind;
    } point_t;

    // Bit positions of P2..P9 in the neighbour vector, clockwise from north.
    localparam int NB_N  = 0;
    localparam int NB_NE = 1;
    localparam int NB_E  = 2;
    localparam int NB_SE = 3;
    localparam int NB_S  = 4;
    localparam int NB_SW = 5;
    localparam int NB_W  = 6;
    localparam int NB_NW = 7;

    // Number of set neighbours.
    function automatic logic [3:0] count_set(input logic [7:0] nb);
        logic [3:0] total;
        total = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (nb[i]) begin
                total = total + 4'd1;
            end
        end
        return total;
    endfunction

    // Number of 0->1 steps walking the neighbours once round the ring.
    function automatic logic [3:0] count_rises(input logic [7:0] nb);
        logic [3:0] total;
        total = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (!nb[i] && nb[(i + 1) % 8]) begin
                total = total + 4'd1;
            end
        end
        return total;
    endfunction

endpackage

// File: rtl/skeleton_keypoint_extractor_if.sv
// Pixel stream, keypoint drain port and frame report of the keypoint extractor.
// master is the surrounding system (pixel source and keypoint consumer).
// slave is the extractor itself.
interface skeleton_keypoint_extractor_if #(
    parameter int HORIZONTAL_COUNT = 320,
    parameter int VERTICAL_COUNT   = 180,
    parameter int COUNT_WIDTH      = 8
);
    localparam int XW = $clog2(HORIZONTAL_COUNT);
    localparam int YW = $clog2(VERTICAL_COUNT);

    logic [XW-1:0]          hcount_in;
    logic [YW-1:0]          vcount_in;
    logic                   pixel_in;
    logic                   pixel_valid_in;
    logic [XW-1:0]          point_x_out;
    logic [YW-1:0]          point_y_out;
    logic                   point_type_out;
    logic                   point_valid_out;
    logic                   point_ready_in;
    logic                   frame_done_out;
    logic [COUNT_WIDTH-1:0] endpoint_count_out;
    logic [COUNT_WIDTH-1:0] junction_count_out;
    logic                   overflow_out;

    modport master (
        output hcount_in, vcount_in, pixel_in, pixel_valid_in, point_ready_in,
        input  point_x_out, point_y_out, point_type_out, point_valid_out,
        input  frame_done_out, endpoint_count_out, junction_count_out, overflow_out
    );

    modport slave (
        input  hcount_in, vcount_in, pixel_in, pixel_valid_in, point_ready_in,
        output point_x_out, point_y_out, point_type_out, point_valid_out,
        output frame_done_out, endpoint_count_out, junction_count_out, overflow_out
    );

endinterface

// File: rtl/skeleton_keypoint_extractor_point_fifo.sv
// First-word-fall-through FIFO of keypoints; the head is visible whenever not empty.
// Pushes while full and pops while empty are ignored.
module point_fifo
    import skel_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic   clk_in,
    input  logic   rst_in,
    input  logic   push,
    input  point_t push_data,
    output logic   full,
    input  logic   pop,
    output point_t pop_data,
    output logic   empty
);
    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    point_t        mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy move together on each accepted push/pop.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/skeleton_keypoint_extractor.sv
// Classifies skeleton pixels as endpoints or junctions from a 3x3 window
// built out of two row buffers, queues the keypoints and reports per-frame totals.
// The window is formed from the incoming column plus the two previous columns,
// so the centre under test always lags the incoming pixel by one row and one column.
module skeleton_keypoint_extractor
    import skel_pkg::*;
#(
    parameter int HORIZONTAL_COUNT = 320,
    parameter int VERTICAL_COUNT   = 180,
    parameter int FIFO_DEPTH       = 16,
    parameter int COUNT_WIDTH      = 8
) (
    input logic clk_in,
    input logic rst_in,
    skeleton_keypoint_extractor_if.slave bus
);
    localparam int XW = $clog2(HORIZONTAL_COUNT);
    localparam int YW = $clog2(VERTICAL_COUNT);

    logic [HORIZONTAL_COUNT-1:0] row1_q;
    logic [HORIZONTAL_COUNT-1:0] row2_q;
    logic [2:0]                  col1_q;
    logic [2:0]                  col2_q;
    logic [2:0]                  col_new;
    logic [7:0]                  nb;
    logic                        centre;
    logic                        in_range;
    logic                        is_end;
    logic                        is_junc;
    logic                        first_pixel;
    logic                        last_pixel;

    logic                        det_valid_q;
    point_t                      det_q;
    logic                        frame_active_q;
    logic                        last_pending_q;

    logic [COUNT_WIDTH-1:0]      end_work_q;
    logic [COUNT_WIDTH-1:0]      junc_work_q;
    logic                        ovf_work_q;
    logic [COUNT_WIDTH-1:0]      end_next;
    logic [COUNT_WIDTH-1:0]      junc_next;
    logic                        ovf_next;

    logic [COUNT_WIDTH-1:0]      end_report_q;
    logic [COUNT_WIDTH-1:0]      junc_report_q;
    logic                        ovf_report_q;
    logic                        frame_done_q;

    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        push;
    point_t                      head;

    // Column bits: [2] two rows up, [1] one row up (centre row), [0] current row.
    assign col_new = {row2_q[bus.hcount_in], row1_q[bus.hcount_in], bus.pixel_in};
    assign centre  = col1_q[1];

    assign nb[NB_N]  = col1_q[2];
    assign nb[NB_NE] = col_new[2];
    assign nb[NB_E]  = col_new[1];
    assign nb[NB_SE] = col_new[0];
    assign nb[NB_S]  = col1_q[0];
    assign nb[NB_SW] = col2_q[0];
    assign nb[NB_W]  = col2_q[1];
    assign nb[NB_NW] = col2_q[2];

    assign in_range = bus.pixel_valid_in
                   && (bus.hcount_in >= XW'(2)) && (bus.hcount_in <= XW'(HORIZONTAL_COUNT - 1))
                   && (bus.vcount_in >= YW'(2)) && (bus.vcount_in <= YW'(VERTICAL_COUNT - 1));
    assign is_end   = centre && (count_set(nb) == 4'd1);
    assign is_junc  = centre && (count_rises(nb) >= 4'd3) && !is_end;

    assign first_pixel = bus.pixel_valid_in && (bus.hcount_in == '0) && (bus.vcount_in == '0);
    assign last_pixel  = bus.pixel_valid_in
                      && (bus.hcount_in == XW'(HORIZONTAL_COUNT - 1))
                      && (bus.vcount_in == YW'(VERTICAL_COUNT - 1));

    // Row buffers and window columns advance only on accepted pixels.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            row1_q <= '0;
            row2_q <= '0;
            col1_q <= '0;
            col2_q <= '0;
        end else if (bus.pixel_valid_in) begin
            row1_q[bus.hcount_in] <= bus.pixel_in;
            row2_q[bus.hcount_in] <= row1_q[bus.hcount_in];
            col2_q                <= col1_q;
            col1_q                <= col_new;
        end
    end

    // Register the classification of the centre one row up and one column left.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            det_valid_q <= 1'b0;
            det_q       <= '0;
        end else begin
            det_valid_q <= in_range && (is_end || is_junc);
            if (in_range) begin
                det_q.point_x    <= POINT_X_WIDTH'(bus.hcount_in - XW'(1));
                det_q.point_y    <= POINT_Y_WIDTH'(bus.vcount_in - YW'(1));
                det_q.point_kind <= is_end ? ENDPOINT : JUNCTION;
            end
        end
    end

    assign push = det_valid_q && !fifo_full;

    // Next working totals: every detection counts, drops raise the overflow flag.
    always_comb begin
        end_next  = end_work_q;
        junc_next = junc_work_q;
        ovf_next  = ovf_work_q;
        if (det_valid_q) begin
            if (det_q.point_kind == ENDPOINT) begin
                if (end_work_q != {COUNT_WIDTH{1'b1}}) begin
                    end_next = end_work_q + COUNT_WIDTH'(1);
                end
            end else begin
                if (junc_work_q != {COUNT_WIDTH{1'b1}}) begin
                    junc_next = junc_work_q + COUNT_WIDTH'(1);
                end
            end
            if (fifo_full) begin
                ovf_next = 1'b1;
            end
        end
    end

    // Frame bookkeeping: restart totals at pixel (0,0), publish them after the last pixel.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            end_work_q     <= '0;
            junc_work_q    <= '0;
            ovf_work_q     <= 1'b0;
            end_report_q   <= '0;
            junc_report_q  <= '0;
            ovf_report_q   <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_active_q <= 1'b0;
            last_pending_q <= 1'b0;
        end else begin
            frame_done_q   <= 1'b0;
            last_pending_q <= last_pixel && frame_active_q;
            if (last_pending_q) begin
                frame_done_q  <= 1'b1;
                end_report_q  <= end_next;
                junc_report_q <= junc_next;
                ovf_report_q  <= ovf_next;
            end
            if (first_pixel) begin
                frame_active_q <= 1'b1;
                end_work_q     <= '0;
                junc_work_q    <= '0;
                ovf_work_q     <= 1'b0;
            end else begin
                end_work_q  <= end_next;
                junc_work_q <= junc_next;
                ovf_work_q  <= ovf_next;
            end
        end
    end

    point_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_point_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (push),
        .push_data (det_q),
        .full      (fifo_full),
        .pop       (bus.point_ready_in),
        .pop_data  (head),
        .empty     (fifo_empty)
    );

    assign bus.point_x_out        = head.point_x[XW-1:0];
    assign bus.point_y_out        = head.point_y[YW-1:0];
    assign bus.point_type_out     = head.point_kind;
    assign bus.point_valid_out    = !fifo_empty;
    assign bus.frame_done_out     = frame_done_q;
    assign bus.endpoint_count_out = end_report_q;
    assign bus.junction_count_out = junc_report_q;
    assign bus.overflow_out       = ovf_report_q;

endmodule

// File: tb/tb_skeleton_keypoint_extractor.sv
// Self-checking bench for the skeleton keypoint extractor on a small 8x6 frame.
// Expected keypoints come from a direct geometric scan of the frame image.
`timescale 1ns/1ps
module tb_skeleton_keypoint_extractor;

    localparam int H   = 8;
    localparam int V   = 6;
    localparam int D   = 2;
    localparam int CW  = 3;
    localparam int SAT = (1 << CW) - 1;
    localparam int XW  = $clog2(H);
    localparam int YW  = $clog2(V);

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    skeleton_keypoint_extractor_if #(
        .HORIZONTAL_COUNT(H), .VERTICAL_COUNT(V), .COUNT_WIDTH(CW)
    ) bus ();

    skeleton_keypoint_extractor #(
        .HORIZONTAL_COUNT(H), .VERTICAL_COUNT(V), .FIFO_DEPTH(D), .COUNT_WIDTH(CW)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int total_checks = 0;
    int bad_checks   = 0;
    bit img [V][H];
    int expected_q[$];
    int got_q[$];
    int exp_end;
    int exp_junc;
    int done_seen = 0;

    function automatic int encode(int x, int y, int t);
        return (x << 16) | (y << 8) | t;
    endfunction

    function automatic int sat(int n);
        return (n > SAT) ? SAT : n;
    endfunction

    // -1 = not a keypoint, 0 = endpoint, 1 = junction.
    function automatic int classify(int x, int y);
        int dx[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
        int dy[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
        int nbv[8];
        int b;
        int a;
        if (!img[y][x]) return -1;
        b = 0;
        a = 0;
        for (int i = 0; i < 8; i++) begin
            nbv[i] = img[y + dy[i]][x + dx[i]] ? 1 : 0;
            b += nbv[i];
        end
        for (int i = 0; i < 8; i++) begin
            if (nbv[i] == 0 && nbv[(i + 1) % 8] == 1) a++;
        end
        if (b == 1) return 0;
        if (a >= 3) return 1;
        return -1;
    endfunction

    function automatic void buildExpected();
        int k;
        expected_q.delete();
        exp_end  = 0;
        exp_junc = 0;
        for (int y = 1; y <= V - 2; y++) begin
            for (int x = 1; x <= H - 2; x++) begin
                k = classify(x, y);
                if (k >= 0) begin
                    expected_q.push_back(encode(x, y, k));
                    if (k == 0) exp_end++;
                    else exp_junc++;
                end
            end
        end
    endfunction

    function automatic void clearImage();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                img[y][x] = 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int headCode();
        return encode(int'(bus.point_x_out), int'(bus.point_y_out), int'(bus.point_type_out));
    endfunction

    // Record every pop and every frame report away from the active edge.
    always @(negedge clk_in) begin
        if (!rst_in && bus.point_valid_out && bus.point_ready_in) got_q.push_back(headCode());
        if (!rst_in && bus.frame_done_out) done_seen++;
    end

    // Stream npix pixels of img in raster order, with random idle cycles in between.
    task automatic applyStimulus(input int gap_pct, input int npix);
        int sent = 0;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (sent < npix) begin
                    while ($urandom_range(99) < gap_pct) begin
                        @(posedge clk_in); #1;
                        bus.pixel_valid_in = 1'b0;
                        bus.pixel_in       = 1'($urandom_range(1));
                        bus.hcount_in      = XW'($urandom_range(H - 1));
                        bus.vcount_in      = YW'($urandom_range(V - 1));
                    end
                    @(posedge clk_in); #1;
                    bus.pixel_valid_in = 1'b1;
                    bus.hcount_in      = XW'(x);
                    bus.vcount_in      = YW'(y);
                    bus.pixel_in       = img[y][x];
                    sent++;
                end
            end
        end
        @(posedge clk_in); #1;
        bus.pixel_valid_in = 1'b0;
    endtask

    task automatic waitDone(input int prev);
        for (int i = 0; i < 40 && done_seen == prev; i++) @(posedge clk_in);
        #1;
        checkOutput("frame_done_pulses", done_seen - prev, 1);
    endtask

    // Full frame with the consumer always ready: nothing is dropped.
    task automatic runFrame(input string tag, input int gap_pct);
        int prev;
        buildExpected();
        got_q.delete();
        prev = done_seen;
        applyStimulus(gap_pct, H * V);
        waitDone(prev);
        repeat (4) @(posedge clk_in);
        #1;
        checkOutput({tag, "_npts"}, got_q.size(), expected_q.size());
        for (int i = 0; i < expected_q.size() && i < got_q.size(); i++)
            checkOutput({tag, "_pt"}, got_q[i], expected_q[i]);
        checkOutput({tag, "_endcnt"}, bus.endpoint_count_out, sat(exp_end));
        checkOutput({tag, "_junccnt"}, bus.junction_count_out, sat(exp_junc));
        checkOutput({tag, "_ovf"}, bus.overflow_out, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int prev;
        int dens;
        bus.pixel_valid_in = 1'b0;
        bus.pixel_in       = 1'b0;
        bus.hcount_in      = '0;
        bus.vcount_in      = '0;
        bus.point_ready_in = 1'b1;
        #1 rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        checkOutput("rst_valid", bus.point_valid_out, 0);
        checkOutput("rst_x", bus.point_x_out, 0);
        checkOutput("rst_y", bus.point_y_out, 0);
        checkOutput("rst_type", bus.point_type_out, 0);
        checkOutput("rst_done", bus.frame_done_out, 0);
        checkOutput("rst_endcnt", bus.endpoint_count_out, 0);
        checkOutput("rst_junccnt", bus.junction_count_out, 0);
        checkOutput("rst_ovf", bus.overflow_out, 0);
        rst_in = 1'b0;

        $display("[TB] horizontal line");
        clearImage();
        for (int x = 1; x <= 5; x++) img[2][x] = 1'b1;
        runFrame("hline", 20);

        $display("[TB] T shape");
        clearImage();
        for (int x = 1; x <= 5; x++) img[2][x] = 1'b1;
        img[3][3] = 1'b1;
        img[4][3] = 1'b1;
        runFrame("tshape", 20);

        $display("[TB] isolated and border pixels");
        clearImage();
        img[3][4] = 1'b1;
        img[2][0] = 1'b1;
        runFrame("isolated", 20);

        $display("[TB] overflow with consumer stalled");
        clearImage();
        img[1][1] = 1'b1; img[1][2] = 1'b1;
        img[1][4] = 1'b1; img[1][5] = 1'b1;
        img[4][1] = 1'b1; img[4][2] = 1'b1;
        img[4][4] = 1'b1; img[4][5] = 1'b1;
        buildExpected();
        got_q.delete();
        bus.point_ready_in = 1'b0;
        prev = done_seen;
        applyStimulus(20, H * V);
        waitDone(prev);
        checkOutput("ovf_endcnt", bus.endpoint_count_out, sat(exp_end));
        checkOutput("ovf_junccnt", bus.junction_count_out, sat(exp_junc));
        checkOutput("ovf_flag", bus.overflow_out, expected_q.size() > D);
        checkOutput("ovf_head_valid", bus.point_valid_out, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_in); #1;
            checkOutput("hold_head", headCode(), expected_q[0]);
        end
        bus.point_ready_in = 1'b1;
        @(posedge clk_in); #1;
        bus.point_ready_in = 1'b0;
        checkOutput("pulse_next_head", headCode(), expected_q[1]);
        checkOutput("pulse_next_valid", bus.point_valid_out, 1);
        bus.point_ready_in = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;
        checkOutput("drain_count", got_q.size(), D);
        for (int i = 0; i < D && i < got_q.size(); i++)
            checkOutput("drain_pt", got_q[i], expected_q[i]);
        checkOutput("drain_valid", bus.point_valid_out, 0);

        $display("[TB] reset in mid frame");
        clearImage();
        for (int x = 1; x <= 5; x++) img[2][x] = 1'b1;
        img[3][3] = 1'b1;
        img[4][3] = 1'b1;
        bus.point_ready_in = 1'b0;
        prev = done_seen;
        applyStimulus(0, 4 * H + 2);
        repeat (2) @(posedge clk_in);
        #1;
        checkOutput("prerst_valid", bus.point_valid_out, 1);
        #2 rst_in = 1'b1;
        #1;
        checkOutput("midrst_valid", bus.point_valid_out, 0);
        checkOutput("midrst_endcnt", bus.endpoint_count_out, 0);
        checkOutput("midrst_junccnt", bus.junction_count_out, 0);
        checkOutput("midrst_ovf", bus.overflow_out, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        bus.point_ready_in = 1'b1;
        repeat (10) @(posedge clk_in);
        #1;
        checkOutput("no_done_partial", done_seen, prev);
        clearImage();
        for (int x = 1; x <= 5; x++) img[2][x] = 1'b1;
        img[3][3] = 1'b1;
        img[4][3] = 1'b1;
        runFrame("postrst", 20);

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            dens = $urandom_range(30, 60);
            for (int y = 0; y < V; y++)
                for (int x = 0; x < H; x++)
                    img[y][x] = ($urandom_range(99) < dens);
            runFrame("rand", 25);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
